// File: rtl/t_toggle_counter.sv
// rtl/t_toggle_counter.sv - modulo-N up/down counter exposing a per-bit T toggle mask
// t_vec drives the downstream JK-as-T stages; count_q is a local copy for cross-checking.
module t_toggle_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap,
  output logic             ld_err
);

  // One extra bit so MOD = 2^WIDTH is representable in the load range check.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ld_err_q, ld_err_d;

  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    ld_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if ({1'b0, d} < MOD_W) begin
        count_d = d;
      end else begin
        count_d  = '0;
        ld_err_d = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        if (count_q == MAX_Q) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_Q;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q  <= '0;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign q      = count_q;
  assign qbar   = ~count_q;
  assign t_vec  = count_q ^ count_d;
  assign tc     = en & (up_dn ? (count_q == MAX_Q) : (count_q == '0));
  assign wrap   = wrap_q;
  assign ld_err = ld_err_q;

endmodule
